// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: defaults for 640x480@60, sync polarity constants, the
// control-bundle type carried through the delay line, and a clog2 helper
// used for counter-width checks at elaboration.
package vga_timing_pkg;

  // 640x480@60 horizontal timing (pixel columns)
  localparam int DEF_VIDEO_WIDTH   = 3;
  localparam int DEF_ACTIVE_COLS   = 640;
  localparam int DEF_H_FRONT_PORCH = 16;
  localparam int DEF_H_SYNC        = 96;
  localparam int DEF_H_BACK_PORCH  = 48;

  // 640x480@60 vertical timing (lines)
  localparam int DEF_ACTIVE_ROWS   = 480;
  localparam int DEF_V_FRONT_PORCH = 10;
  localparam int DEF_V_SYNC        = 2;
  localparam int DEF_V_BACK_PORCH  = 33;

  // Asserted level of a sync output
  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // Pixel-source latency limit and test-pattern geometry
  localparam int MAX_PIPE_DELAY = 15;
  localparam int NUM_BARS       = 8;
  localparam int BAR_IDX_WIDTH  = 3;

  // Coordinate-domain control terms that travel alongside the pixel pipeline.
  // All-zero is the idle value (blanked, syncs deasserted).
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } vga_ctl_t;

  // Number of bits needed to count 0..value-1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage shift register that realigns coordinate-domain
// terms with the pixel source's output. DEPTH = 0 is a plain wire. Every
// stage clears to RESET_VAL on the asynchronous active-low reset.
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_direct
      // No latency to match: pass straight through. Clock and reset are
      // intentionally unused in this configuration.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      // Next contents: new sample enters stage 0, everything else moves up one.
      always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      // Stage registers, cleared to the idle value on reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RESET_VAL;
          end
        end else begin
          stage_q <= stage_d;
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing core. Produces column/row coordinates
// and coordinate-aligned flags for the pixel source, then delays the
// active/sync terms by PIPE_DELAY cycles so they meet the pixel source's
// output, and registers blanked video plus programmable-polarity syncs.
// Pins lag the coordinate by PIPE_DELAY+1 cycles.
//
// Optional build macro VGA_TEST_PATTERN_EN adds i_Pattern_En and an
// eight-bar colour pattern that can replace the incoming video.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int VIDEO_WIDTH   = DEF_VIDEO_WIDTH,
  parameter int ACTIVE_COLS   = DEF_ACTIVE_COLS,
  parameter int H_FRONT_PORCH = DEF_H_FRONT_PORCH,
  parameter int H_SYNC        = DEF_H_SYNC,
  parameter int H_BACK_PORCH  = DEF_H_BACK_PORCH,
  parameter int ACTIVE_ROWS   = DEF_ACTIVE_ROWS,
  parameter int V_FRONT_PORCH = DEF_V_FRONT_PORCH,
  parameter int V_SYNC        = DEF_V_SYNC,
  parameter int V_BACK_PORCH  = DEF_V_BACK_PORCH,
  parameter bit HSYNC_POL     = SYNC_ACTIVE_LOW,
  parameter bit VSYNC_POL     = SYNC_ACTIVE_LOW,
  parameter int PIPE_DELAY    = 2,
  parameter int COUNT_WIDTH   = 10
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_Enable,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                   i_Pattern_En,
`endif
  output logic [COUNT_WIDTH-1:0] o_Col,
  output logic [COUNT_WIDTH-1:0] o_Row,
  output logic                   o_Active,
  output logic                   o_Line_Start,
  output logic                   o_Frame_Start,
  input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);

  localparam int TOTAL_COLS = ACTIVE_COLS + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int TOTAL_ROWS = ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;

  // Thresholds sized to the counters so every compare is width-matched.
  // Sync windows use an inclusive last position so a zero back porch
  // never needs a value one past the counter range.
  localparam logic [COUNT_WIDTH-1:0] LAST_COL   = COUNT_WIDTH'(TOTAL_COLS - 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_ROW   = COUNT_WIDTH'(TOTAL_ROWS - 1);
  localparam logic [COUNT_WIDTH-1:0] ACT_COLS_C = COUNT_WIDTH'(ACTIVE_COLS);
  localparam logic [COUNT_WIDTH-1:0] ACT_ROWS_C = COUNT_WIDTH'(ACTIVE_ROWS);
  localparam logic [COUNT_WIDTH-1:0] HS_FIRST_C = COUNT_WIDTH'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [COUNT_WIDTH-1:0] HS_LAST_C  = COUNT_WIDTH'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC - 1);
  localparam logic [COUNT_WIDTH-1:0] VS_FIRST_C = COUNT_WIDTH'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [COUNT_WIDTH-1:0] VS_LAST_C  = COUNT_WIDTH'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC - 1);

  // Reject configurations the counters or delay line cannot represent.
  generate
    if (COUNT_WIDTH < clog2(TOTAL_COLS) || COUNT_WIDTH < clog2(TOTAL_ROWS)) begin : g_bad_count_width
      $error("vga_timing_gen: COUNT_WIDTH cannot hold TOTAL_COLS-1 / TOTAL_ROWS-1");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > MAX_PIPE_DELAY) begin : g_bad_pipe_delay
      $error("vga_timing_gen: PIPE_DELAY outside 0..15");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Coordinate domain
  // ---------------------------------------------------------------------
  // parked_q marks the idle (0,0) position held during reset and disable;
  // the first enabled cycle after parking presents (0,0) again, this time
  // with the flags raised, so the pixel source always sees a frame start.
  logic                   parked_q,      parked_d;
  logic [COUNT_WIDTH-1:0] col_q,         col_d;
  logic [COUNT_WIDTH-1:0] row_q,         row_d;
  logic                   active_q,      active_d;
  logic                   line_start_q,  line_start_d;
  logic                   frame_start_q, frame_start_d;

  // Next raster position and the flags that belong to it.
  always_comb begin
    parked_d = parked_q;
    col_d    = col_q;
    row_d    = row_q;
    if (!i_Enable) begin
      parked_d = 1'b1;
      col_d    = '0;
      row_d    = '0;
    end else begin
      parked_d = 1'b0;
      if (parked_q) begin
        col_d = '0;
        row_d = '0;
      end else if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    active_d      = i_Enable && (col_d < ACT_COLS_C) && (row_d < ACT_ROWS_C);
    line_start_d  = i_Enable && (col_d == '0);
    frame_start_d = i_Enable && (col_d == '0) && (row_d == '0);
  end

  // Coordinate and flag registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      parked_q      <= 1'b1;
      col_q         <= '0;
      row_q         <= '0;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      parked_q      <= parked_d;
      col_q         <= col_d;
      row_q         <= row_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_Col         = col_q;
  assign o_Row         = row_q;
  assign o_Active      = active_q;
  assign o_Line_Start  = line_start_q;
  assign o_Frame_Start = frame_start_q;

  // Raw (undelayed, positive-true) control terms for the current position.
  // Gated by parked_q so a parked counter never emits sync.
  vga_ctl_t ctl_raw;
  vga_ctl_t ctl_dly;

  // Sync windows decoded from the current coordinate; vsync spans whole lines.
  always_comb begin
    ctl_raw.active = active_q;
    ctl_raw.hsync  = !parked_q && (col_q >= HS_FIRST_C) && (col_q <= HS_LAST_C);
    ctl_raw.vsync  = !parked_q && (row_q >= VS_FIRST_C) && (row_q <= VS_LAST_C);
  end

  vga_delay_line #(
    .WIDTH     ($bits(vga_ctl_t)),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL ('0)
  ) u_ctl_delay (
    .clk   (i_Clk),
    .rst_n (i_Rst_L),
    .din   (ctl_raw),
    .dout  (ctl_dly)
  );

`ifdef VGA_TEST_PATTERN_EN
  // ---------------------------------------------------------------------
  // Test pattern: eight equal vertical bars across the active width. The bar
  // index follows the column by compare-and-reset so no divider is needed.
  // ---------------------------------------------------------------------
  localparam logic [COUNT_WIDTH-1:0] BAR_LAST = COUNT_WIDTH'(ACTIVE_COLS / NUM_BARS - 1);

  generate
    if (ACTIVE_COLS % NUM_BARS != 0) begin : g_bad_bar_width
      $error("vga_timing_gen: ACTIVE_COLS must split into 8 equal bars");
    end
  endgenerate

  logic [COUNT_WIDTH-1:0]   bar_cnt_q, bar_cnt_d;
  logic [BAR_IDX_WIDTH-1:0] bar_idx_q, bar_idx_d;
  logic [BAR_IDX_WIDTH-1:0] bar_idx_dly;

  // Bar position tracks col_d: restart at column 0, step every BAR_LAST+1 columns.
  always_comb begin
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (col_d == '0) begin
      bar_cnt_d = '0;
      bar_idx_d = '0;
    end else if (bar_cnt_q == BAR_LAST) begin
      bar_cnt_d = '0;
      bar_idx_d = bar_idx_q + 1'b1;
    end else begin
      bar_cnt_d = bar_cnt_q + 1'b1;
    end
  end

  // Bar counter registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
    end else begin
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  vga_delay_line #(
    .WIDTH     (BAR_IDX_WIDTH),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL ('0)
  ) u_bar_delay (
    .clk   (i_Clk),
    .rst_n (i_Rst_L),
    .din   (bar_idx_q),
    .dout  (bar_idx_dly)
  );
`endif

  // ---------------------------------------------------------------------
  // Output register: polarity applied and video blanked outside active area
  // ---------------------------------------------------------------------
  logic                   hsync_q, hsync_d;
  logic                   vsync_q, vsync_d;
  logic [VIDEO_WIDTH-1:0] red_q,   red_d;
  logic [VIDEO_WIDTH-1:0] grn_q,   grn_d;
  logic [VIDEO_WIDTH-1:0] blu_q,   blu_d;

  // Pin values from the delay-aligned control terms.
  always_comb begin
    hsync_d = ctl_dly.hsync ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = ctl_dly.vsync ? VSYNC_POL : ~VSYNC_POL;
    red_d   = '0;
    grn_d   = '0;
    blu_d   = '0;
    if (ctl_dly.active) begin
`ifdef VGA_TEST_PATTERN_EN
      if (i_Pattern_En) begin
        red_d = {VIDEO_WIDTH{bar_idx_dly[0]}};
        grn_d = {VIDEO_WIDTH{bar_idx_dly[1]}};
        blu_d = {VIDEO_WIDTH{bar_idx_dly[2]}};
      end else begin
        red_d = i_Red_Video;
        grn_d = i_Grn_Video;
        blu_d = i_Blu_Video;
      end
`else
      red_d = i_Red_Video;
      grn_d = i_Grn_Video;
      blu_d = i_Blu_Video;
`endif
    end
  end

  // Pin registers; reset puts syncs at their deasserted level.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      red_q   <= '0;
      grn_q   <= '0;
      blu_q   <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      red_q   <= red_d;
      grn_q   <= grn_d;
      blu_q   <= blu_d;
    end
  end

  assign o_HSync     = hsync_q;
  assign o_VSync     = vsync_q;
  assign o_Red_Video = red_q;
  assign o_Grn_Video = grn_q;
  assign o_Blu_Video = blu_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: two reduced-geometry instances (one with a 3-stage
// pixel latency and active-low syncs, one with zero latency and active-high
// syncs) driven by shared random stimulus. Each stimulus cycle pushes the
// reference model's expectation into a per-instance queue; a separate
// monitor pops and compares after every clock edge.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  // Instance A geometry: 24 x 10 raster, PIPE_DELAY 3, active-low syncs
  localparam int A_AC = 16, A_HFP = 2, A_HSW = 3, A_HBP = 3;
  localparam int A_AR = 5,  A_VFP = 1, A_VSW = 2, A_VBP = 2;
  localparam int A_PD = 3,  A_CW = 5;
  localparam bit A_HPOL = SYNC_ACTIVE_LOW, A_VPOL = SYNC_ACTIVE_LOW;
  // Instance B geometry: 40 x 10 raster, PIPE_DELAY 0, active-high syncs
  localparam int B_AC = 24, B_HFP = 4, B_HSW = 5, B_HBP = 7;
  localparam int B_AR = 4,  B_VFP = 2, B_VSW = 1, B_VBP = 3;
  localparam int B_PD = 0,  B_CW = 6;
  localparam bit B_HPOL = SYNC_ACTIVE_HIGH, B_VPOL = SYNC_ACTIVE_HIGH;

`ifdef VGA_TEST_PATTERN_EN
  localparam bit PAT_BUILT = 1'b1;
`else
  localparam bit PAT_BUILT = 1'b0;
`endif

  localparam int HIST = 8;

  typedef struct {
    int ac, hfp, hsw, hbp, ar, vfp, vsw, vbp, pd;
    bit hpol, vpol;
  } cfg_t;

  typedef struct packed {
    logic [7:0] col;
    logic [7:0] row;
    logic       active, ls, fs, hs, vs;
    logic [2:0] r, g, b;
  } exp_t;

  typedef struct packed {
    logic       run, active, hs, vs;
    logic [2:0] bar;
    logic [7:0] col, row;
  } rec_t;

  int checks = 0;
  int failures = 0;

  logic clk, rst_n, en, pen;
  logic [2:0] vr, vg, vb;
  int pen_mode;

  logic [A_CW-1:0] a_col, a_row;
  logic [B_CW-1:0] b_col, b_row;
  logic a_active, a_ls, a_fs, a_hs, a_vs, b_active, b_ls, b_fs, b_hs, b_vs;
  logic [2:0] a_r, a_g, a_b, b_r, b_g, b_b;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t last_ea;
  int   run_cnt [2];
  rec_t hist [2][HIST];

  vga_timing_gen #(
    .VIDEO_WIDTH(3), .ACTIVE_COLS(A_AC), .H_FRONT_PORCH(A_HFP), .H_SYNC(A_HSW),
    .H_BACK_PORCH(A_HBP), .ACTIVE_ROWS(A_AR), .V_FRONT_PORCH(A_VFP), .V_SYNC(A_VSW),
    .V_BACK_PORCH(A_VBP), .HSYNC_POL(A_HPOL), .VSYNC_POL(A_VPOL),
    .PIPE_DELAY(A_PD), .COUNT_WIDTH(A_CW)
  ) dut_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en),
`ifdef VGA_TEST_PATTERN_EN
    .i_Pattern_En(pen),
`endif
    .o_Col(a_col), .o_Row(a_row), .o_Active(a_active), .o_Line_Start(a_ls),
    .o_Frame_Start(a_fs), .i_Red_Video(vr), .i_Grn_Video(vg), .i_Blu_Video(vb),
    .o_HSync(a_hs), .o_VSync(a_vs), .o_Red_Video(a_r), .o_Grn_Video(a_g), .o_Blu_Video(a_b)
  );

  vga_timing_gen #(
    .VIDEO_WIDTH(3), .ACTIVE_COLS(B_AC), .H_FRONT_PORCH(B_HFP), .H_SYNC(B_HSW),
    .H_BACK_PORCH(B_HBP), .ACTIVE_ROWS(B_AR), .V_FRONT_PORCH(B_VFP), .V_SYNC(B_VSW),
    .V_BACK_PORCH(B_VBP), .HSYNC_POL(B_HPOL), .VSYNC_POL(B_VPOL),
    .PIPE_DELAY(B_PD), .COUNT_WIDTH(B_CW)
  ) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en),
`ifdef VGA_TEST_PATTERN_EN
    .i_Pattern_En(pen),
`endif
    .o_Col(b_col), .o_Row(b_row), .o_Active(b_active), .o_Line_Start(b_ls),
    .o_Frame_Start(b_fs), .i_Red_Video(vr), .i_Grn_Video(vg), .i_Blu_Video(vb),
    .o_HSync(b_hs), .o_VSync(b_vs), .o_Red_Video(b_r), .o_Grn_Video(b_g), .o_Blu_Video(b_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic cfg_t cfg(input int d);
    cfg_t c;
    if (d == 0) begin
      c.ac = A_AC; c.hfp = A_HFP; c.hsw = A_HSW; c.hbp = A_HBP;
      c.ar = A_AR; c.vfp = A_VFP; c.vsw = A_VSW; c.vbp = A_VBP;
      c.pd = A_PD; c.hpol = A_HPOL; c.vpol = A_VPOL;
    end else begin
      c.ac = B_AC; c.hfp = B_HFP; c.hsw = B_HSW; c.hbp = B_HBP;
      c.ar = B_AR; c.vfp = B_VFP; c.vsw = B_VSW; c.vbp = B_VBP;
      c.pd = B_PD; c.hpol = B_HPOL; c.vpol = B_VPOL;
    end
    return c;
  endfunction

  // Reference model: position is simply the number of consecutive enabled
  // edges since the last reset/disable, folded onto the raster by div/mod.
  // Pins look back PIPE_DELAY+1 edges in a history of positions.
  task automatic model_step(input int d, output exp_t e);
    cfg_t c;
    rec_t cur, old;
    int tc, tr, p, col, row;
    c  = cfg(d);
    tc = c.ac + c.hfp + c.hsw + c.hbp;
    tr = c.ar + c.vfp + c.vsw + c.vbp;
    if (!rst_n || !en) run_cnt[d] = 0;
    else               run_cnt[d] = run_cnt[d] + 1;
    cur = '0;
    if (run_cnt[d] > 0) begin
      p   = run_cnt[d] - 1;
      col = p % tc;
      row = (p / tc) % tr;
      cur.run    = 1'b1;
      cur.col    = 8'(col);
      cur.row    = 8'(row);
      cur.active = (col < c.ac) && (row < c.ar);
      cur.hs     = (col >= c.ac + c.hfp) && (col < c.ac + c.hfp + c.hsw);
      cur.vs     = (row >= c.ar + c.vfp) && (row < c.ar + c.vfp + c.vsw);
      cur.bar    = 3'(col / (c.ac / 8));
    end
    for (int i = HIST - 1; i > 0; i--) hist[d][i] = hist[d][i-1];
    if (!rst_n) for (int i = 0; i < HIST; i++) hist[d][i] = '0;
    hist[d][0] = cur;
    old = hist[d][c.pd + 1];
    e = '0;
    e.col    = cur.col;
    e.row    = cur.row;
    e.active = cur.active;
    e.ls     = cur.run && (cur.col == 8'd0);
    e.fs     = cur.run && (cur.col == 8'd0) && (cur.row == 8'd0);
    e.hs     = old.hs ? c.hpol : !c.hpol;
    e.vs     = old.vs ? c.vpol : !c.vpol;
    if (old.active) begin
      if (PAT_BUILT && pen) begin
        e.r = {3{old.bar[0]}};
        e.g = {3{old.bar[1]}};
        e.b = {3{old.bar[2]}};
      end else begin
        e.r = vr; e.g = vg; e.b = vb;
      end
    end
  endtask

  function automatic exp_t sample(input int d);
    exp_t s;
    s = '0;
    if (d == 0) begin
      s.col = 8'(a_col); s.row = 8'(a_row); s.active = a_active; s.ls = a_ls; s.fs = a_fs;
      s.hs = a_hs; s.vs = a_vs; s.r = a_r; s.g = a_g; s.b = a_b;
    end else begin
      s.col = 8'(b_col); s.row = 8'(b_row); s.active = b_active; s.ls = b_ls; s.fs = b_fs;
      s.hs = b_hs; s.vs = b_vs; s.r = b_r; s.g = b_g; s.b = b_b;
    end
    return s;
  endfunction

  task automatic cmp(input string what, input int d, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", what, d, act, req, $time);
    end
  endtask

  task automatic cmp_all(input string tag, input int d, input exp_t act, input exp_t req);
    cmp({tag, ".col"},         d, act.col,    req.col);
    cmp({tag, ".row"},         d, act.row,    req.row);
    cmp({tag, ".active"},      d, 8'(act.active), 8'(req.active));
    cmp({tag, ".line_start"},  d, 8'(act.ls), 8'(req.ls));
    cmp({tag, ".frame_start"}, d, 8'(act.fs), 8'(req.fs));
    cmp({tag, ".hsync"},       d, 8'(act.hs), 8'(req.hs));
    cmp({tag, ".vsync"},       d, 8'(act.vs), 8'(req.vs));
    cmp({tag, ".red"},         d, 8'(act.r),  8'(req.r));
    cmp({tag, ".grn"},         d, 8'(act.g),  8'(req.g));
    cmp({tag, ".blu"},         d, 8'(act.b),  8'(req.b));
  endtask

  // Values every output must take while reset is held.
  function automatic exp_t reset_exp(input int d);
    exp_t e;
    cfg_t c;
    c = cfg(d);
    e = '0;
    e.hs = !c.hpol;
    e.vs = !c.vpol;
    return e;
  endfunction

  // One stimulus cycle: drive inputs mid-cycle, record what the next edge must produce.
  task automatic step(input logic r, input logic e_v);
    exp_t ea, eb;
    logic falling;
    falling = rst_n & ~r;
    rst_n = r;
    en    = e_v;
    vr    = 3'($urandom);
    vg    = 3'($urandom);
    vb    = 3'($urandom);
    pen   = (pen_mode == 2) ? 1'($urandom) : (pen_mode == 1);
    model_step(0, ea);
    model_step(1, eb);
    sb_a.push_back(ea);
    sb_b.push_back(eb);
    last_ea = ea;
    if (falling) begin
      #1;
      cmp_all("async_reset", 0, sample(0), reset_exp(0));
      cmp_all("async_reset", 1, sample(1), reset_exp(1));
    end
    @(posedge clk);
    #6;
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b1, 1'b1);
  endtask

  // Monitor: every edge presents one output set per instance.
  initial begin
    forever begin
      @(posedge clk);
      #4;
      if (sb_a.size() > 0) cmp_all("edge", 0, sample(0), sb_a.pop_front());
      if (sb_b.size() > 0) cmp_all("edge", 1, sample(1), sb_b.pop_front());
    end
  end

  // Watchdog bound on the whole run.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n, found;
    rst_n = 1'b0;
    en = 1'b0;
    pen = 1'b0;
    pen_mode = 0;
    vr = '0; vg = '0; vb = '0;

    $display("phase: reset hold");
    repeat (3) step(1'b0, 1'b1);

    $display("phase: free run 600 cycles, pass-through video");
    run(600);
    $display("phase: pattern select high / random");
    pen_mode = 1; run(300);
    pen_mode = 2; run(300);
    pen_mode = 0;

    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(30, 400));
      $display("phase: run %0d then disable", n);
      run(n);
      n = int'($urandom_range(1, 60));
      repeat (n) step(1'b1, 1'b0);
    end

    $display("phase: reset during horizontal sync");
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      step(1'b1, 1'b1);
      if (last_ea.hs == A_HPOL) found = 1;
    end
    checks++;
    if (found == 0) begin
      failures++;
      $display("FAIL find_hsync actual=not_found required=found t=%0t", $time);
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    run(400);

    for (int k = 0; k < 3; k++) begin
      n = int'($urandom_range(50, 300));
      $display("phase: run %0d then random reset", n);
      run(n);
      n = int'($urandom_range(1, 3));
      repeat (n) step(1'b0, 1'($urandom));
    end
    run(500);

    // Let the monitor consume the final expectation.
    for (int k = 0; k < 5 && (sb_a.size() > 0 || sb_b.size() > 0); k++) begin
      @(posedge clk);
      #5;
    end
    if (sb_a.size() > 0 || sb_b.size() > 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 t=%0t", sb_a.size() + sb_b.size(), $time);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
